// File: rtl/vz_image_loader.sv
// ----------------------------------------------------------------------------
// vz_image_loader
//
// Turns the OSD "Load VZ Image" ioctl download stream into Z80 RAM writes.
// The 24-byte VZ header is parsed (type byte at offset 21, little-endian
// load address at offsets 22/23). Payload bytes go into a small FIFO and are
// written through a request/acknowledge port. After the payload, BASIC
// images get their program start/end system variables patched.
//
// Optional feature (macro VZ_AUTORUN_EN): machine-code (F1) images also get
// the autorun jump vector patched with the load address.
//
// Ports
//   clk_sys, reset            clock, synchronous active-high reset
//   dn_download/index/wr/     ioctl download stream from hps_io
//   addr/data
//   mem_addr/wdata/we         RAM write request, held until mem_ack
//   mem_ack                   single-cycle accept pulse from the RAM arbiter
//   busy                      loader active, CPU must be held in wait
//   loaded / err              sticky result of the last load
//   file_type                 header type byte (F0 BASIC, F1 machine code)
// ----------------------------------------------------------------------------
module vz_image_loader #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [7:0]  VZ_INDEX        = 8'd1,
    parameter logic [15:0] RAM_BASE        = 16'h7800,
    parameter logic [15:0] BASIC_START_PTR = 16'h78A4,
    parameter logic [15:0] BASIC_END_PTR   = 16'h78F9,
    parameter logic [15:0] AUTORUN_VEC     = 16'h788E
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dn_download,
    input  logic [7:0]  dn_index,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        busy,
    output logic        loaded,
    output logic        err,
    output logic [7:0]  file_type
);

`ifdef VZ_AUTORUN_EN
    localparam bit AUTORUN = 1'b1;
`else
    localparam bit AUTORUN = 1'b0;
`endif

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [7:0]  FT_BASIC = 8'hF0;
    localparam logic [7:0]  FT_MCODE = 8'hF1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_FIX, S_DONE, S_ERR
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   start_q, start_d;
    logic [15:0]   len_q, len_d;
    wr_t           fifo_q [FIFO_DEPTH];
    wr_t           fifo_d [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    fix_idx_q, fix_idx_d;
    logic          mem_we_q, mem_we_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;
    logic          loaded_q, loaded_d;
    logic          err_q, err_d;
    logic [7:0]    file_type_q, file_type_d;

    logic          sel, rise, acc, addr_ok, pop, push, go_err, wrap, fix_basic;
    logic [1:0]    fix_last;
    logic [15:0]   end_addr;
    logic [16:0]   addr_sum;
    wr_t           push_entry, fix_next;

    // Pointer-patch writes: idx 0/1 = start lo/hi, idx 2/3 = end lo/hi.
    // Non-BASIC images only use idx 0/1 against the autorun vector.
    function automatic wr_t fix_entry(input logic [1:0] idx, input logic basic,
                                      input logic [15:0] st, input logic [15:0] en);
        wr_t         w;
        logic [15:0] base;
        logic [15:0] val;
        base   = basic ? (idx[1] ? BASIC_END_PTR : BASIC_START_PTR) : AUTORUN_VEC;
        val    = (basic && idx[1]) ? en : st;
        w.addr = base + {15'd0, idx[0]};
        w.data = idx[0] ? val[15:8] : val[7:0];
        return w;
    endfunction

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        start_d     = start_q;
        len_d       = len_q;
        fifo_d      = fifo_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fix_idx_d   = fix_idx_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        loaded_d    = loaded_q;
        err_d       = err_q;
        file_type_d = file_type_q;

        sel        = dn_download && (dn_index == VZ_INDEX);
        sel_d      = sel;
        rise       = sel && !sel_q;
        acc        = dn_wr && sel;
        addr_ok    = (dn_addr == cnt_q);
        pop        = 1'b0;
        push       = 1'b0;
        go_err     = 1'b0;
        addr_sum   = {1'b0, start_q} + {1'b0, len_q};
        wrap       = addr_sum[16];
        push_entry = '{addr: addr_sum[15:0], data: dn_data};
        end_addr   = start_q + len_q;
        fix_basic  = (file_type_q == FT_BASIC);
        fix_last   = fix_basic ? 2'd3 : 2'd1;
        fix_next   = fix_entry(fix_idx_q + 2'd1, fix_basic, start_q, end_addr);

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d     = S_HDR;
                    busy_d      = 1'b1;
                    loaded_d    = 1'b0;
                    err_d       = 1'b0;
                    cnt_d       = 16'd0;
                    len_d       = 16'd0;
                    start_d     = 16'd0;
                    file_type_d = 8'd0;
                    // A byte arriving together with the download edge is offset 0.
                    if (acc) begin
                        if (dn_addr == 16'd0) cnt_d = 16'd1;
                        else                  go_err = 1'b1;
                    end
                end
            end

            S_HDR: begin
                if (!dn_download) begin
                    go_err = 1'b1;
                end else if (acc) begin
                    if (!addr_ok) begin
                        go_err = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q == 16'd21) file_type_d   = dn_data;
                        if (cnt_q == 16'd22) start_d[7:0]  = dn_data;
                        if (cnt_q == 16'd23) begin
                            start_d[15:8] = dn_data;
                            if (({dn_data, start_q[7:0]} < RAM_BASE) ||
                                !(file_type_q == FT_BASIC || file_type_q == FT_MCODE))
                                go_err = 1'b1;
                            else
                                state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                pop = mem_we_q && mem_ack;
                if (acc) begin
                    // Full FIFO may still take a byte if the head leaves this cycle.
                    if (!addr_ok || wrap || (count_q == FULL_CNT && !pop)) begin
                        go_err = 1'b1;
                    end else begin
                        push             = 1'b1;
                        fifo_d[wr_ptr_q] = push_entry;
                        wr_ptr_d         = wr_ptr_q + AW'(1);
                        len_d            = len_q + 16'd1;
                        cnt_d            = cnt_q + 16'd1;
                    end
                end
                if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
                // Registered head: reading fifo_d covers the push-into-empty bypass.
                mem_we_d = (count_d != '0);
                if (count_d != '0) {mem_addr_d, mem_wdata_d} = fifo_d[rd_ptr_d];

                if (!dn_download && count_q == '0) begin
                    if (fix_basic || AUTORUN) begin
                        state_d   = S_FIX;
                        fix_idx_d = 2'd0;
                        mem_we_d  = 1'b1;
                        {mem_addr_d, mem_wdata_d} = fix_entry(2'd0, fix_basic, start_q, end_addr);
                    end else begin
                        state_d  = S_DONE;
                        loaded_d = 1'b1;
                        busy_d   = 1'b0;
                    end
                end
            end

            S_FIX: begin
                if (mem_we_q && mem_ack) begin
                    if (fix_idx_q == fix_last) begin
                        state_d  = S_DONE;
                        mem_we_d = 1'b0;
                        loaded_d = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        fix_idx_d = fix_idx_q + 2'd1;
                        {mem_addr_d, mem_wdata_d} = fix_next;
                    end
                end
            end

            S_DONE: state_d = S_IDLE;

            S_ERR: begin
                if (!dn_download) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        if (go_err) begin
            state_d  = S_ERR;
            mem_we_d = 1'b0;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            err_d    = 1'b1;
            loaded_d = 1'b0;
            busy_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            // Track the live level so a download still running across reset
            // is not mistaken for a fresh start.
            sel_q       <= sel;
            cnt_q       <= 16'd0;
            start_q     <= 16'd0;
            len_q       <= 16'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            fix_idx_q   <= 2'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 8'd0;
            busy_q      <= 1'b0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
            file_type_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            len_q       <= len_d;
            fifo_q      <= fifo_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fix_idx_q   <= fix_idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
            file_type_q <= file_type_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign loaded    = loaded_q;
    assign err       = err_q;
    assign file_type = file_type_q;

endmodule

// File: tb/tb_vz_image_loader.sv
module tb_vz_image_loader;

`ifdef VZ_AUTORUN_EN
    localparam bit AUTORUN = 1'b1;
`else
    localparam bit AUTORUN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dn_download;
    logic [7:0]  dn_index;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_ack;
    logic        busy;
    logic        loaded;
    logic        err;
    logic [7:0]  file_type;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    bit  ack_en  = 1'b1;
    int  ack_max = 1;

    always #5 clk_sys = ~clk_sys;

    vz_image_loader dut (
        .clk_sys(clk_sys), .reset(reset),
        .dn_download(dn_download), .dn_index(dn_index), .dn_wr(dn_wr),
        .dn_addr(dn_addr), .dn_data(dn_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack),
        .busy(busy), .loaded(loaded), .err(err), .file_type(file_type)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM arbiter model: acknowledges each pending write after a random delay.
    initial begin : responder
        int wcnt;
        int dly;
        wcnt    = 0;
        dly     = 0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            mem_ack = 1'b0;
            if (mem_we && ack_en && !reset) begin
                if (wcnt >= dly) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                    dly     = $urandom_range(0, ack_max);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: every accepted write is matched against the scoreboard.
    logic        prev_we = 1'b0;
    logic        prev_ack = 1'b0;
    logic [23:0] prev_wr = '0;
    always @(negedge clk_sys) begin : monitor
        wr_t e;
        if (!reset && mem_we && mem_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h=%h expected none", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", {16'd0, mem_addr}, {16'd0, e.a});
                chk("write_data", {24'd0, mem_wdata}, {24'd0, e.d});
            end
        end
        if (!reset && prev_we && !prev_ack && mem_we)
            chk("hold_stable", {8'd0, mem_addr, mem_wdata}, {8'd0, prev_wr});
        prev_we  = mem_we && !reset;
        prev_ack = mem_ack;
        prev_wr  = {mem_addr, mem_wdata};
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl();
        dn_index    = 8'd1;
        dn_download = 1'b1;
        tick(1);
    endtask

    task automatic send_byte(input logic [15:0] off, input logic [7:0] d, input int gap);
        dn_wr   = 1'b1;
        dn_addr = off;
        dn_data = d;
        tick(1);
        dn_wr = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    function automatic logic [7:0] hdr_byte(input int o, input logic [7:0] ft, input logic [15:0] st);
        logic [31:0] magic;
        magic = 32'h565A4630; // "VZF0"
        if (o < 4)   return magic[31-8*o -: 8];
        if (o == 21) return ft;
        if (o == 22) return st[7:0];
        if (o == 23) return st[15:8];
        return 8'($urandom_range(8'h41, 8'h5A));
    endfunction

    task automatic send_header(input logic [7:0] ft, input logic [15:0] st, input int gap, input int n);
        for (int o = 0; o < n; o++) send_byte(16'(o), hdr_byte(o, ft, st), gap);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick(1);
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    // Reference: a valid image writes its payload at start.., then BASIC gets
    // start/end pointers and (with autorun) machine code gets the jump vector.
    task automatic do_load(input logic [7:0] ft, input logic [15:0] st, input bq_t pl, input int gap);
        int          len;
        bit          ok;
        logic [15:0] en;
        len = pl.size();
        ok  = (st >= 16'h7800) && (ft == 8'hF0 || ft == 8'hF1) && (32'(st) + len <= 32'h10000);
        en  = st + 16'(len);
        if (ok) begin
            for (int i = 0; i < len; i++) exp_q.push_back('{a: st + 16'(i), d: pl[i]});
            if (ft == 8'hF0) begin
                exp_q.push_back('{a: 16'h78A4, d: st[7:0]});
                exp_q.push_back('{a: 16'h78A5, d: st[15:8]});
                exp_q.push_back('{a: 16'h78F9, d: en[7:0]});
                exp_q.push_back('{a: 16'h78FA, d: en[15:8]});
            end else if (AUTORUN) begin
                exp_q.push_back('{a: 16'h788E, d: st[7:0]});
                exp_q.push_back('{a: 16'h788F, d: st[15:8]});
            end
        end
        start_dl();
        chk("busy_on_start", {31'd0, busy}, 32'd1);
        send_header(ft, st, gap, 23);
        chk("hdr_no_err_22", {31'd0, err}, 32'd0);
        send_byte(16'd23, st[15:8], gap);
        if (!ok) chk("hdr_err_23", {31'd0, err}, 32'd1);
        for (int i = 0; i < len; i++) send_byte(16'(24 + i), pl[i], gap);
        dn_download = 1'b0;
        wait_idle("load_timeout");
        tick(2);
        chk("loaded", {31'd0, loaded}, {31'd0, ok});
        chk("err", {31'd0, err}, {31'd0, !ok});
        if (ok) chk("file_type", {24'd0, file_type}, {24'd0, ft});
        chk("writes_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bq_t         pl;
        logic [7:0]  ft;
        logic [15:0] st;
        int          len;
        int          gap;

        reset       = 1'b1;
        dn_download = 1'b0;
        dn_index    = 8'd0;
        dn_wr       = 1'b0;
        dn_addr     = 16'd0;
        dn_data     = 8'd0;
        tick(3);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_loaded", {31'd0, loaded}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_out", {mem_addr, mem_wdata, file_type}, 32'd0);
        reset = 1'b0;
        tick(2);

        // BASIC image at 7AE9, payload 11 22 33
        ack_max = 1;
        pl = {};
        pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        do_load(8'hF0, 16'h7AE9, pl, 2);

        // machine-code image at 8000, two bytes
        pl = {};
        pl.push_back(8'hA5); pl.push_back(8'h5A);
        do_load(8'hF1, 16'h8000, pl, 2);

        // zero-length BASIC payload, lowest legal start
        pl = {};
        do_load(8'hF0, 16'h7800, pl, 1);

        // start below RAM, and an unknown type byte
        pl = {};
        pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h03);
        do_load(8'hF0, 16'h4000, pl, 1);
        do_load(8'hF5, 16'h9000, pl, 1);

        // FIFO overflow: no acks, a byte every 2nd cycle
        ack_en = 1'b0;
        start_dl();
        send_header(8'hF0, 16'h7AE9, 1, 24);
        for (int i = 0; i < 4; i++) send_byte(16'(24 + i), 8'(i), 1);
        chk("ovf_not_yet", {31'd0, err}, 32'd0);
        chk("ovf_we_pending", {31'd0, mem_we}, 32'd1);
        send_byte(16'd28, 8'h44, 1);
        chk("ovf_err", {31'd0, err}, 32'd1);
        chk("ovf_we_dropped", {31'd0, mem_we}, 32'd0);
        chk("ovf_not_busy", {31'd0, busy}, 32'd0);
        dn_download = 1'b0;
        tick(3);
        ack_en = 1'b1;

        // download ends inside the header
        start_dl();
        send_header(8'hF0, 16'h7AE9, 1, 10);
        dn_download = 1'b0;
        wait_idle("short_timeout");
        tick(1);
        chk("short_err", {31'd0, err}, 32'd1);
        chk("short_loaded", {31'd0, loaded}, 32'd0);
        chk("short_busy", {31'd0, busy}, 32'd0);

        // reset while a write is pending
        ack_en = 1'b0;
        start_dl();
        send_header(8'hF1, 16'h8000, 1, 24);
        send_byte(16'd24, 8'h77, 1);
        send_byte(16'd25, 8'h88, 1);
        chk("mid_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_loaded", {31'd0, loaded}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        ack_en = 1'b1;
        send_byte(16'd26, 8'h99, 1);
        send_byte(16'd27, 8'hAA, 1);
        dn_download = 1'b0;
        tick(4);
        chk("post_rst_idle", {29'd0, mem_we, busy, err}, 32'd0);

        // randomized images
        for (int k = 0; k < 8; k++) begin
            ft      = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hF1;
            len     = $urandom_range(0, 12);
            st      = 16'($urandom_range(32'h7800, 32'hFFF0 - 32'(len)));
            gap     = $urandom_range(1, 3);
            ack_max = $urandom_range(0, gap);
            pl = {};
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            do_load(ft, st, pl, gap);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
